// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the core LSU and a DMA engine.
// Optional DMEM_ARB_PERF_EN adds stall / DMA-grant cycle counters.
`default_nettype none

module dmem_arbiter #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_c_req,
  input  logic [31:0] i_c_addr,
  input  logic        i_c_wren,
  input  logic [3:0]  i_c_be,
  input  logic [31:0] i_c_wdata,
  output logic        o_c_gnt,
  output logic        o_c_stall,
  output logic [31:0] o_c_rdata,
  output logic        o_c_rvalid,
  input  logic        i_d_req,
  input  logic [31:0] i_d_addr,
  input  logic        i_d_wren,
  input  logic [3:0]  i_d_be,
  input  logic [31:0] i_d_wdata,
  input  logic        i_d_lock,
  output logic        o_d_gnt,
  output logic [31:0] o_d_rdata,
  output logic        o_d_rvalid,
  output logic [31:0] o_m_addr,
  output logic        o_m_wren,
  output logic [3:0]  o_m_be,
  output logic [31:0] o_m_wdata,
`ifdef DMEM_ARB_PERF_EN
  output logic [31:0] o_perf_stall,
  output logic [31:0] o_perf_dgnt,
`endif
  input  logic [31:0] i_m_rdata
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
  localparam logic       PORT_CORE  = 1'b0;
  localparam logic       PORT_DMA   = 1'b1;

  logic       lock_q;
  logic [7:0] starve_q;
  logic [1:0] rtag_q;

  always_comb begin
    o_c_gnt = 1'b0;
    o_d_gnt = 1'b0;
    if (lock_q) begin
      o_d_gnt = i_d_req;
    end else if (i_d_req && (starve_q == STARVE_LIM)) begin
      o_d_gnt = 1'b1;
    end else if (i_c_req) begin
      o_c_gnt = 1'b1;
    end else if (i_d_req) begin
      o_d_gnt = 1'b1;
    end
  end

  assign o_c_stall = i_c_req & ~o_c_gnt;

  always_comb begin
    o_m_addr  = 32'd0;
    o_m_wren  = 1'b0;
    o_m_be    = 4'd0;
    o_m_wdata = 32'd0;
    if (o_c_gnt) begin
      o_m_addr  = i_c_addr;
      o_m_wren  = i_c_wren;
      o_m_be    = i_c_be;
      o_m_wdata = i_c_wdata;
    end else if (o_d_gnt) begin
      o_m_addr  = i_d_addr;
      o_m_wren  = i_d_wren;
      o_m_be    = i_d_be;
      o_m_wdata = i_d_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q   <= 1'b0;
      starve_q <= 8'd0;
      rtag_q   <= 2'b00;
    end else begin
      if (o_d_gnt || !i_d_req) begin
        starve_q <= 8'd0;
      end else if (starve_q != STARVE_LIM) begin
        starve_q <= starve_q + 8'd1;
      end

      if (o_d_gnt && i_d_lock) begin
        lock_q <= 1'b1;
      end else if (o_d_gnt || !i_d_req) begin
        lock_q <= 1'b0;
      end

      // Tag travels with the read so alternating-port reads return to the right owner.
      if (o_c_gnt && !i_c_wren) begin
        rtag_q <= {1'b1, PORT_CORE};
      end else if (o_d_gnt && !i_d_wren) begin
        rtag_q <= {1'b1, PORT_DMA};
      end else begin
        rtag_q <= 2'b00;
      end
    end
  end

  assign o_c_rvalid = rtag_q[1] & (rtag_q[0] == PORT_CORE);
  assign o_d_rvalid = rtag_q[1] & (rtag_q[0] == PORT_DMA);
  assign o_c_rdata  = o_c_rvalid ? i_m_rdata : 32'd0;
  assign o_d_rdata  = o_d_rvalid ? i_m_rdata : 32'd0;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_dgnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_q <= 32'd0;
      perf_dgnt_q  <= 32'd0;
    end else begin
      if (o_c_stall) perf_stall_q <= perf_stall_q + 32'd1;
      if (o_d_gnt)   perf_dgnt_q  <= perf_dgnt_q + 32'd1;
    end
  end

  assign o_perf_stall = perf_stall_q;
  assign o_perf_dgnt  = perf_dgnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// Directed-vector bench for dmem_arbiter (STARVE_MAX = 8).
`default_nettype none

module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_c_req, i_c_wren, i_d_req, i_d_wren, i_d_lock;
  logic [31:0] i_c_addr, i_c_wdata, i_d_addr, i_d_wdata, i_m_rdata;
  logic [3:0]  i_c_be, i_d_be;
  logic        o_c_gnt, o_c_stall, o_c_rvalid, o_d_gnt, o_d_rvalid, o_m_wren;
  logic [31:0] o_c_rdata, o_d_rdata, o_m_addr, o_m_wdata;
  logic [3:0]  o_m_be;

  int n_vec = 0;
  int n_err = 0;

  dmem_arbiter #(.STARVE_MAX(8)) dut (
    .clk(clk), .reset(reset),
    .i_c_req(i_c_req), .i_c_addr(i_c_addr), .i_c_wren(i_c_wren), .i_c_be(i_c_be),
    .i_c_wdata(i_c_wdata), .o_c_gnt(o_c_gnt), .o_c_stall(o_c_stall),
    .o_c_rdata(o_c_rdata), .o_c_rvalid(o_c_rvalid),
    .i_d_req(i_d_req), .i_d_addr(i_d_addr), .i_d_wren(i_d_wren), .i_d_be(i_d_be),
    .i_d_wdata(i_d_wdata), .i_d_lock(i_d_lock), .o_d_gnt(o_d_gnt),
    .o_d_rdata(o_d_rdata), .o_d_rvalid(o_d_rvalid),
    .o_m_addr(o_m_addr), .o_m_wren(o_m_wren), .o_m_be(o_m_be), .o_m_wdata(o_m_wdata),
    .i_m_rdata(i_m_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then changed and checked at +2.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    i_c_req = 0; i_c_addr = 0; i_c_wren = 0; i_c_be = 0; i_c_wdata = 0;
    i_d_req = 0; i_d_addr = 0; i_d_wren = 0; i_d_be = 0; i_d_wdata = 0; i_d_lock = 0;
    i_m_rdata = 32'hFFFF_FFFF;
    #3;
    chk("rst_c_gnt", {31'd0, o_c_gnt}, 0);
    chk("rst_d_gnt", {31'd0, o_d_gnt}, 0);
    chk("rst_c_rvalid", {31'd0, o_c_rvalid}, 0);
    chk("rst_d_rvalid", {31'd0, o_d_rvalid}, 0);
    chk("rst_c_rdata", o_c_rdata, 0);
    chk("rst_d_rdata", o_d_rdata, 0);
    chk("rst_m_wren", {31'd0, o_m_wren}, 0);
    chk("rst_m_addr", o_m_addr, 0);
    tick();
    reset = 1'b1;
    tick();

    // Core-only read
    i_c_req = 1; i_c_addr = 32'h0000_0010; i_c_wren = 0; i_c_be = 4'hF;
    #1;
    chk("cr_gnt", {31'd0, o_c_gnt}, 1);
    chk("cr_stall", {31'd0, o_c_stall}, 0);
    chk("cr_m_addr", o_m_addr, 32'h10);
    chk("cr_m_wren", {31'd0, o_m_wren}, 0);
    tick();
    i_c_req = 0; i_m_rdata = 32'hDEAD_BEEF;
    #1;
    chk("cr_rvalid", {31'd0, o_c_rvalid}, 1);
    chk("cr_rdata", o_c_rdata, 32'hDEAD_BEEF);
    chk("cr_d_rvalid", {31'd0, o_d_rvalid}, 0);
    chk("cr_d_rdata", o_d_rdata, 0);
    tick();

    // Contention: DMA starves for 8 cycles, granted on cycle 8
    i_c_req = 1; i_c_wren = 1; i_c_addr = 32'h0000_0200; i_c_wdata = 32'h1234_5678;
    i_d_req = 1; i_d_wren = 1; i_d_addr = 32'h0000_0300; i_d_be = 4'hF; i_d_wdata = 32'hCAFE_0000;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      chk($sformatf("ct_c_gnt[%0d]", cyc), {31'd0, o_c_gnt}, (cyc == 8) ? 32'd0 : 32'd1);
      chk($sformatf("ct_d_gnt[%0d]", cyc), {31'd0, o_d_gnt}, (cyc == 8) ? 32'd1 : 32'd0);
      chk($sformatf("ct_stall[%0d]", cyc), {31'd0, o_c_stall}, (cyc == 8) ? 32'd1 : 32'd0);
      chk($sformatf("ct_m_addr[%0d]", cyc), o_m_addr, (cyc == 8) ? 32'h300 : 32'h200);
      tick();
    end
    i_c_req = 0; i_d_req = 0;
    tick();

    // DMA locked 4-beat write burst; core requests from beat 1
    for (int b = 0; b < 4; b++) begin
      i_d_req = 1; i_d_wren = 1; i_d_addr = 32'h0000_0100 + 32'(b * 4);
      i_d_wdata = 32'hA000_0000 + 32'(b); i_d_lock = (b < 3);
      i_c_req = (b > 0); i_c_wren = 1; i_c_addr = 32'h0000_0500;
      #1;
      chk($sformatf("lk_d_gnt[%0d]", b), {31'd0, o_d_gnt}, 1);
      chk($sformatf("lk_m_wren[%0d]", b), {31'd0, o_m_wren}, 1);
      chk($sformatf("lk_m_addr[%0d]", b), o_m_addr, 32'h100 + 32'(b * 4));
      chk($sformatf("lk_stall[%0d]", b), {31'd0, o_c_stall}, (b > 0) ? 32'd1 : 32'd0);
      tick();
    end
    i_d_req = 0; i_d_lock = 0;
    #1;
    chk("lk_c_gnt_after", {31'd0, o_c_gnt}, 1);
    chk("lk_m_addr_after", o_m_addr, 32'h500);
    tick();

    // Interleaved reads core then DMA
    i_c_req = 1; i_c_wren = 0; i_c_addr = 32'h0000_0020;
    #1;
    chk("il_c_gnt", {31'd0, o_c_gnt}, 1);
    tick();
    i_c_req = 0; i_d_req = 1; i_d_wren = 0; i_d_addr = 32'h0000_0040; i_m_rdata = 32'h1111_1111;
    #1;
    chk("il_d_gnt", {31'd0, o_d_gnt}, 1);
    chk("il_c_rvalid", {31'd0, o_c_rvalid}, 1);
    chk("il_c_rdata", o_c_rdata, 32'h1111_1111);
    chk("il_d_rvalid0", {31'd0, o_d_rvalid}, 0);
    tick();
    i_d_req = 0; i_m_rdata = 32'h2222_2222;
    #1;
    chk("il_d_rvalid", {31'd0, o_d_rvalid}, 1);
    chk("il_d_rdata", o_d_rdata, 32'h2222_2222);
    chk("il_c_rvalid1", {31'd0, o_c_rvalid}, 0);
    chk("il_c_rdata1", o_c_rdata, 0);
    tick();

    // Reset during a pending DMA read with lock held
    i_d_req = 1; i_d_wren = 0; i_d_lock = 1; i_d_addr = 32'h0000_0080;
    #1;
    chk("rm_d_gnt", {31'd0, o_d_gnt}, 1);
    tick();
    i_m_rdata = 32'h3333_3333;
    reset = 1'b0;
    #1;
    chk("rm_d_rvalid", {31'd0, o_d_rvalid}, 0);
    chk("rm_d_rdata", o_d_rdata, 0);
    tick();
    reset = 1'b1;
    i_c_req = 1; i_c_wren = 1; i_c_addr = 32'h0000_0600;
    #1;
    chk("rm_c_gnt", {31'd0, o_c_gnt}, 1);
    chk("rm_d_gnt_after", {31'd0, o_d_gnt}, 0);
    tick();
    i_c_req = 0; i_d_req = 0; i_d_lock = 0;
    tick();

    // Byte-lane write passthrough
    i_c_req = 1; i_c_wren = 1; i_c_be = 4'b0100; i_c_wdata = 32'h00AB_0000; i_c_addr = 32'h0000_0030;
    #1;
    chk("bw_m_be", {28'd0, o_m_be}, 32'h4);
    chk("bw_m_wdata", o_m_wdata, 32'h00AB_0000);
    chk("bw_m_wren", {31'd0, o_m_wren}, 1);
    chk("bw_m_addr", o_m_addr, 32'h30);
    tick();
    i_c_req = 0;
    #1;
    chk("bw_idle_wren", {31'd0, o_m_wren}, 0);
    chk("bw_idle_be", {28'd0, o_m_be}, 0);
    chk("bw_idle_wdata", o_m_wdata, 0);
    chk("bw_idle_rvalid", {31'd0, o_c_rvalid}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
